// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM with double-buffered valid/ready config; one-cycle registered outputs, cfg_ready low while a channel holds a pending config.
// Optional per-channel output polarity is enabled by defining PWM_POLARITY_EN (adds the cfg_pol input).
module pwm_multi_ch #(
  parameter int CH_NUM  = 4,
  parameter int CNT_W   = 10,
  parameter int PERIOD0 = 500,
  parameter int PERIOD1 = 250,
  parameter int PERIOD2 = 200,
  parameter int PERIOD3 = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_duty,
  input  logic [1:0]        cfg_freq_sel,
`ifdef PWM_POLARITY_EN
  input  logic              cfg_pol,
`endif
  output logic [CH_NUM-1:0] pwm_out,
  output logic [CH_NUM-1:0] config_done,
  output logic              duty_error
);

  function automatic logic [CNT_W-1:0] period_of(input logic [1:0] sel);
    logic [CNT_W-1:0] p;
    case (sel)
      2'd0:    p = CNT_W'(PERIOD0);
      2'd1:    p = CNT_W'(PERIOD1);
      2'd2:    p = CNT_W'(PERIOD2);
      default: p = CNT_W'(PERIOD3);
    endcase
    return p;
  endfunction

  logic [CNT_W-1:0]  cnt_q    [CH_NUM];
  logic [CNT_W-1:0]  cnt_d    [CH_NUM];
  logic [CNT_W-1:0]  duty_a_q [CH_NUM];
  logic [CNT_W-1:0]  duty_a_d [CH_NUM];
  logic [CNT_W-1:0]  duty_s_q [CH_NUM];
  logic [CNT_W-1:0]  duty_s_d [CH_NUM];
  logic [1:0]        fsel_a_q [CH_NUM];
  logic [1:0]        fsel_a_d [CH_NUM];
  logic [1:0]        fsel_s_q [CH_NUM];
  logic [1:0]        fsel_s_d [CH_NUM];
  logic [CH_NUM-1:0] pend_q, pend_d;
  logic [CH_NUM-1:0] pwm_q, pwm_d;
  logic [CH_NUM-1:0] done_q, done_d;
  logic              err_q, err_d;
  logic [CH_NUM-1:0] pol_a;

`ifdef PWM_POLARITY_EN
  logic [CH_NUM-1:0] pol_a_q, pol_a_d;
  logic [CH_NUM-1:0] pol_s_q, pol_s_d;
  assign pol_a = pol_a_q;
`else
  assign pol_a = '0;
`endif

  logic pend_sel;
  logic ch_bad;
  logic accept;
  logic reject;

  // Out-of-range channels never block: they are always accepted and then rejected.
  always_comb begin
    pend_sel = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (cfg_ch == 4'(k)) pend_sel = pend_q[k];
    end
  end

  assign ch_bad    = ({1'b0, cfg_ch} >= 5'(CH_NUM));
  assign cfg_ready = ch_bad | ~pend_sel;
  assign accept    = cfg_valid & cfg_ready;
  assign reject    = ch_bad | (cfg_duty > period_of(cfg_freq_sel));

  always_comb begin
    cnt_d    = cnt_q;
    duty_a_d = duty_a_q;
    duty_s_d = duty_s_q;
    fsel_a_d = fsel_a_q;
    fsel_s_d = fsel_s_q;
    pend_d   = pend_q;
    pwm_d    = '0;
    done_d   = '0;
    err_d    = accept & reject;
`ifdef PWM_POLARITY_EN
    pol_a_d  = pol_a_q;
    pol_s_d  = pol_s_q;
`endif
    for (int k = 0; k < CH_NUM; k++) begin
      pwm_d[k] = (cnt_q[k] < duty_a_q[k]) ^ pol_a[k];

      // Period boundary: wrap, and swap in the shadow config if one is waiting.
      if (cnt_q[k] == period_of(fsel_a_q[k]) - CNT_W'(1)) begin
        cnt_d[k] = '0;
        if (pend_q[k]) begin
          duty_a_d[k] = duty_s_q[k];
          fsel_a_d[k] = fsel_s_q[k];
          pend_d[k]   = 1'b0;
          done_d[k]   = 1'b1;
`ifdef PWM_POLARITY_EN
          pol_a_d[k]  = pol_s_q[k];
`endif
        end
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end

      // Accept needs pend_q[k]==0, so it never collides with the apply above.
      if (accept && !reject && (cfg_ch == 4'(k))) begin
        duty_s_d[k] = cfg_duty;
        fsel_s_d[k] = cfg_freq_sel;
        pend_d[k]   = 1'b1;
`ifdef PWM_POLARITY_EN
        pol_s_d[k]  = cfg_pol;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < CH_NUM; k++) begin
        cnt_q[k]    <= '0;
        duty_a_q[k] <= '0;
        duty_s_q[k] <= '0;
        fsel_a_q[k] <= '0;
        fsel_s_q[k] <= '0;
      end
      pend_q <= '0;
      pwm_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
`ifdef PWM_POLARITY_EN
      pol_a_q <= '0;
      pol_s_q <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      duty_a_q <= duty_a_d;
      duty_s_q <= duty_s_d;
      fsel_a_q <= fsel_a_d;
      fsel_s_q <= fsel_s_d;
      pend_q   <= pend_d;
      pwm_q    <= pwm_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef PWM_POLARITY_EN
      pol_a_q  <= pol_a_d;
      pol_s_q  <= pol_s_d;
`endif
    end
  end

  assign pwm_out     = pwm_q;
  assign config_done = done_q;
  assign duty_error  = err_q;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_chk
    a_cnt_in_period : assert property (@(posedge clk) disable iff (reset)
      cnt_q[g] < period_of(fsel_a_q[g]));
    a_duty_legal : assert property (@(posedge clk) disable iff (reset)
      duty_a_q[g] <= period_of(fsel_a_q[g]));
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: per-cycle comparison against a period-start/modulo model, plus directed literal checks.
module tb_pwm_multi_ch;
  localparam int CH_NUM = 4;
  localparam int CNT_W  = 10;
  localparam int P0 = 500, P1 = 250, P2 = 200, P3 = 100;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [3:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_duty = '0;
  logic [1:0]        cfg_freq_sel = '0;
  logic              cfg_pol = 1'b0;
  logic [CH_NUM-1:0] pwm_out;
  logic [CH_NUM-1:0] config_done;
  logic              duty_error;

  int vectors = 0;
  int miscompares = 0;
  int tb_cyc = 0;

  pwm_multi_ch #(
    .CH_NUM(CH_NUM), .CNT_W(CNT_W),
    .PERIOD0(P0), .PERIOD1(P1), .PERIOD2(P2), .PERIOD3(P3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_duty(cfg_duty),
    .cfg_freq_sel(cfg_freq_sel),
`ifdef PWM_POLARITY_EN
    .cfg_pol(cfg_pol),
`endif
    .pwm_out(pwm_out),
    .config_done(config_done),
    .duty_error(duty_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  function automatic int per_of(input logic [1:0] s);
    case (s)
      2'd0:    return P0;
      2'd1:    return P1;
      2'd2:    return P2;
      default: return P3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, tb_cyc);
    end
  endtask

  // Model: each channel's count is (cycle - period_start) mod period.
  int  m_per [CH_NUM], m_duty [CH_NUM], m_t0 [CH_NUM];
  int  m_sper [CH_NUM], m_sduty [CH_NUM];
  bit  m_pend [CH_NUM], m_pol [CH_NUM], m_spol [CH_NUM];
  logic [CH_NUM-1:0] exp_pwm, exp_done;
  logic exp_err;
  bit  model_valid = 0;
  int  now = 0;

  function automatic bit model_ready();
    if (int'(cfg_ch) >= CH_NUM) return 1'b1;
    return !m_pend[cfg_ch];
  endfunction

  always @(posedge clk) begin : model
    bit rdy;
    int pos;
    if (reset) begin
      for (int k = 0; k < CH_NUM; k++) begin
        m_per[k] = P0; m_duty[k] = 0; m_t0[k] = now + 1; m_pend[k] = 0;
        m_sper[k] = P0; m_sduty[k] = 0; m_pol[k] = 0; m_spol[k] = 0;
      end
      exp_pwm = '0; exp_done = '0; exp_err = 1'b0;
      model_valid = 1;
    end else begin
      rdy = model_ready();
      for (int k = 0; k < CH_NUM; k++) begin
        pos = (now - m_t0[k]) % m_per[k];
        exp_pwm[k]  = (pos < m_duty[k]) ^ m_pol[k];
        exp_done[k] = 1'b0;
        if (pos == m_per[k] - 1 && m_pend[k]) begin
          m_duty[k] = m_sduty[k]; m_per[k] = m_sper[k]; m_pol[k] = m_spol[k];
          m_pend[k] = 0; m_t0[k] = now + 1; exp_done[k] = 1'b1;
        end
      end
      exp_err = 1'b0;
      if (cfg_valid && rdy) begin
        if (int'(cfg_ch) >= CH_NUM || int'(cfg_duty) > per_of(cfg_freq_sel)) begin
          exp_err = 1'b1;
        end else begin
          m_sduty[cfg_ch] = int'(cfg_duty);
          m_sper[cfg_ch]  = per_of(cfg_freq_sel);
          m_spol[cfg_ch]  = cfg_pol;
          m_pend[cfg_ch]  = 1;
        end
      end
    end
    now++;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
      check("config_done", 32'(config_done), 32'(exp_done));
      check("duty_error", 32'(duty_error), 32'(exp_err));
      check("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int ch, input int duty, input int fs);
    cfg_ch = 4'(ch); cfg_duty = CNT_W'(duty); cfg_freq_sel = 2'(fs);
    cfg_pol = 1'b0; cfg_valid = 1'b1;
    #1;
    for (int n = 0; n < 2000 && !cfg_ready; n++) tick();
    if (!cfg_ready) check("send_ready_timeout", 32'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int k, input int bound, output int lat);
    lat = -1;
    for (int n = 1; n <= bound; n++) begin
      tick();
      if (config_done[k]) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check("wait_done_timeout", 32'(config_done[k]), 1);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cnt_h, cnt_d, cnt_e, lat, d0, d1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pwm", 32'(pwm_out), 0);
    check("reset_done", 32'(config_done), 0);
    check("reset_err", 32'(duty_error), 0);
    check("reset_ready", 32'(cfg_ready), 1);
    reset = 1'b0;

    cnt_h = 0; cnt_d = 0; cnt_e = 0;
    repeat (1000) begin
      tick();
      cnt_h += $countones(pwm_out);
      cnt_d += $countones(config_done);
      cnt_e += int'(duty_error);
    end
    check("idle_pwm_highs", 32'(cnt_h), 0);
    check("idle_done_pulses", 32'(cnt_d), 0);
    check("idle_err_pulses", 32'(cnt_e), 0);

    // ch0: 100 of every 500 cycles high
    send(0, 100, 0);
    wait_done(0, 600, lat);
    check("ch0_apply_latency_le_500", 32'(lat >= 1 && lat <= 500), 1);
    cnt_h = 0;
    repeat (1000) begin tick(); cnt_h += int'(pwm_out[0]); end
    check("ch0_highs_in_1000", 32'(cnt_h), 200);

    // ch1: duty above period is rejected
    send(1, 101, 3);
    check("ch1_err_pulse", 32'(duty_error), 1);
    tick();
    check("ch1_err_one_cycle", 32'(duty_error), 0);
    check("ch1_ready_stays_high", 32'(cfg_ready), 1);
    cnt_h = 0; cnt_e = 0;
    repeat (200) begin tick(); cnt_h += int'(pwm_out[1]); cnt_e += int'(duty_error); end
    check("ch1_output_unchanged", 32'(cnt_h), 0);
    check("ch1_no_more_errors", 32'(cnt_e), 0);

    // ch2: duty 0 then duty == period, second request blocked while pending
    send(2, 0, 2);
    cfg_ch = 4'd2; cfg_duty = CNT_W'(200); cfg_freq_sel = 2'd2; cfg_valid = 1'b1;
    #1;
    check("ch2_ready_low_while_pending", 32'(cfg_ready), 0);
    for (int n = 0; n < 600 && !cfg_ready; n++) tick();
    check("ch2_ready_rises_with_done", 32'(config_done[2]), 1);
    tick();
    cfg_valid = 1'b0;
    cnt_h = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      cnt_h += int'(pwm_out[2]);
      if (config_done[2]) break;
    end
    check("ch2_duty0_const_low", 32'(cnt_h), 0);
    check("ch2_second_done", 32'(config_done[2]), 1);
    cnt_h = 0;
    repeat (400) begin tick(); cnt_h += int'(pwm_out[2]); end
    check("ch2_full_duty_const_high", 32'(cnt_h), 400);

    // ch3: mid-period change lets the old 500-cycle period finish
    send(3, 250, 0);
    wait_done(3, 600, lat);
    d0 = tb_cyc;
    repeat (123) tick();
    send(3, 50, 3);
    wait_done(3, 600, lat);
    d1 = tb_cyc;
    check("ch3_old_period_completes", 32'(d1 - d0), 500);
    check("ch3_last_old_cycle_low", 32'(pwm_out[3]), 0);
    cnt_h = 0;
    tick();
    check("ch3_new_period_starts_high", 32'(pwm_out[3]), 1);
    cnt_h += int'(pwm_out[3]);
    repeat (299) begin tick(); cnt_h += int'(pwm_out[3]); end
    check("ch3_50_of_100_highs", 32'(cnt_h), 150);

    // Randomized traffic including invalid channels and oversized duties
    for (int n = 0; n < 4000; n++) begin
      int fs;
      tick();
      fs = int'($urandom_range(0, 3));
      cfg_valid    = ($urandom_range(0, 3) == 0);
      cfg_ch       = 4'($urandom_range(0, 5));
      cfg_freq_sel = 2'(fs);
      if ($urandom_range(0, 3) != 0) cfg_duty = CNT_W'($urandom_range(0, per_of(2'(fs))));
      else                           cfg_duty = CNT_W'($urandom_range(0, 1023));
`ifdef PWM_POLARITY_EN
      cfg_pol = 1'($urandom_range(0, 1));
`endif
    end
    tick();
    cfg_valid = 1'b0;

    // Reset right after an accept drops the pending config
    send(0, 30, 1);
    reset = 1'b1;
    tick();
    check("midreset_pwm", 32'(pwm_out), 0);
    check("midreset_done", 32'(config_done), 0);
    check("midreset_err", 32'(duty_error), 0);
    reset = 1'b0;
    cnt_h = 0; cnt_d = 0;
    repeat (1200) begin
      tick();
      cnt_h += $countones(pwm_out);
      cnt_d += $countones(config_done);
    end
    check("dropped_cfg_never_done", 32'(cnt_d), 0);
    check("after_reset_const_low", 32'(cnt_h), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
